// File: rtl/sequence_serializer.sv
// rtl/sequence_serializer.sv - word-to-bit serializer with one-deep holding register
// Optional even-parity trailer bit enabled by defining SEQUENCE_SERIALIZER_PARITY_EN.
module sequence_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             bit_last,
  output logic             busy
);

`ifdef SEQUENCE_SERIALIZER_PARITY_EN
  localparam int FRAME_LEN = WIDTH + 1;
`else
  localparam int FRAME_LEN = WIDTH;
`endif
  localparam int CNT_W = $clog2(FRAME_LEN);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t             state;
  logic [WIDTH-1:0]   shreg;
  logic [WIDTH-1:0]   hold;
  logic               hold_full;
  logic [CNT_W-1:0]   cnt;

  logic               accept;
  logic               last;
  logic               load_sh;
  logic [WIDTH-1:0]   load_word;
  logic [WIDTH-1:0]   shifted;
  logic               data_bit;

  assign load_ready = ~hold_full;
  assign accept     = load_valid & load_ready;
  assign last       = (state == SHIFT) && (cnt == CNT_W'(FRAME_LEN - 1));

  // The shifter reloads either from idle or on the final bit, preferring the held word.
  assign load_sh   = ((state == IDLE) && accept) || (last && (hold_full || accept));
  assign load_word = hold_full ? hold : load_data;

  assign data_bit = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
  assign shifted  = MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};

`ifdef SEQUENCE_SERIALIZER_PARITY_EN
  logic parity;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      parity <= 1'b0;
    end else if (load_sh) begin
      parity <= ^load_word;
    end
  end

  assign bit_out = (state == SHIFT) && ((cnt == CNT_W'(WIDTH)) ? parity : data_bit);
`else
  assign bit_out = (state == SHIFT) && data_bit;
`endif

  assign bit_valid = (state == SHIFT);
  assign bit_last  = last;
  assign busy      = (state == SHIFT) || hold_full;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      shreg     <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
      cnt       <= '0;
    end else begin
      if (load_sh) begin
        shreg <= load_word;
        cnt   <= '0;
        state <= SHIFT;
      end else if (state == SHIFT) begin
        if (last) begin
          state <= IDLE;
          shreg <= '0;
          cnt   <= '0;
        end else begin
          shreg <= shifted;
          cnt   <= cnt + CNT_W'(1);
        end
      end

      // A word arriving mid-frame parks in the holding register until the frame ends.
      if (last && hold_full) begin
        hold_full <= 1'b0;
      end else if (accept && (state == SHIFT) && !last) begin
        hold      <= load_data;
        hold_full <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sequence_serializer.sv
// tb/tb_sequence_serializer.sv - directed self-checking bench for sequence_serializer
module tb_sequence_serializer;

`ifdef SEQUENCE_SERIALIZER_PARITY_EN
  localparam int LEN = 9;
`else
  localparam int LEN = 8;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] load_data = '0;
  logic       load_valid = 1'b0;
  logic       load_ready, bit_out, bit_valid, bit_last, busy;

  logic [7:0] lsb_data = '0;
  logic       lsb_valid = 1'b0;
  logic       lsb_ready, lsb_bit, lsb_bvalid, lsb_blast, lsb_busy;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  sequence_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_dut (
    .clk(clk), .reset(reset), .load_data(load_data), .load_valid(load_valid),
    .load_ready(load_ready), .bit_out(bit_out), .bit_valid(bit_valid),
    .bit_last(bit_last), .busy(busy)
  );

  sequence_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .reset(reset), .load_data(lsb_data), .load_valid(lsb_valid),
    .load_ready(lsb_ready), .bit_out(lsb_bit), .bit_valid(lsb_bvalid),
    .bit_last(lsb_blast), .busy(lsb_busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic frame_bit(input logic [7:0] w, input int pos, input bit msb);
    if (pos >= 8) return ^w;
    return msb ? w[7-pos] : w[pos];
  endfunction

  // Present one word from idle and check the full MSB-first frame, then return to idle.
  task automatic send_and_check(input string tag, input logic [7:0] w);
    load_data  = w;
    load_valid = 1'b1;
    @(negedge clk);
    load_valid = 1'b0;
    load_data  = ~w;
    for (int i = 0; i < LEN; i++) begin
      check($sformatf("%s_valid%0d", tag, i), bit_valid, 1'b1);
      check($sformatf("%s_bit%0d", tag, i), bit_out, frame_bit(w, i, 1'b1));
      check($sformatf("%s_last%0d", tag, i), bit_last, (i == LEN - 1));
      @(negedge clk);
    end
    check({tag, "_idle_valid"}, bit_valid, 1'b0);
    check({tag, "_idle_bit"}, bit_out, 1'b0);
    check({tag, "_idle_busy"}, busy, 1'b0);
  endtask

  initial begin
    logic [7:0] w3 [3];
    logic [7:0] wa, wb, wc;
    int         idx, acc3, s;
    logic       pv, pr;

    w3[0] = 8'h81; w3[1] = 8'hC3; w3[2] = 8'h5A;

    repeat (3) @(negedge clk);
    check("rst_ready", load_ready, 1'b1);
    check("rst_valid", bit_valid, 1'b0);
    check("rst_last", bit_last, 1'b0);
    check("rst_bit", bit_out, 1'b0);
    check("rst_busy", busy, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    check("post_rst_ready", load_ready, 1'b1);
    check("post_rst_busy", busy, 1'b0);

    send_and_check("a5", 8'hA5);

    // Back-to-back 00 then FF with load_valid held until the second word is taken
    load_data  = 8'h00;
    load_valid = 1'b1;
    @(negedge clk);
    check("b2b_ready_c0", load_ready, 1'b1);
    load_data = 8'hFF;
    for (int c = 0; c < 2 * LEN; c++) begin
      wa = (c < LEN) ? 8'h00 : 8'hFF;
      if (c == 1) begin
        check("b2b_ready_held", load_ready, 1'b0);
        check("b2b_busy_held", busy, 1'b1);
        load_valid = 1'b0;
      end
      check($sformatf("b2b_valid%0d", c), bit_valid, 1'b1);
      check($sformatf("b2b_bit%0d", c), bit_out, frame_bit(wa, c % LEN, 1'b1));
      check($sformatf("b2b_last%0d", c), bit_last, (c == LEN - 1) || (c == 2 * LEN - 1));
      @(negedge clk);
    end
    check("b2b_idle", bit_valid, 1'b0);

    // Three words offered continuously
    idx = 0; acc3 = -1; pv = 1'b0; pr = 1'b0;
    for (int c = 0; c <= 3 * LEN + 1; c++) begin
      if (pv && pr) begin
        idx++;
        if (idx == 3) acc3 = c - 1;
      end
      if (c >= 1 && c <= 3 * LEN) begin
        s  = c - 1;
        wb = w3[s / LEN];
        check($sformatf("tri_valid%0d", s), bit_valid, 1'b1);
        check($sformatf("tri_bit%0d", s), bit_out, frame_bit(wb, s % LEN, 1'b1));
        check($sformatf("tri_last%0d", s), bit_last, (s % LEN) == LEN - 1);
      end
      if (c == 3 * LEN + 1) check("tri_idle", bit_valid, 1'b0);
      pv = (idx < 3);
      load_valid = pv;
      load_data  = pv ? w3[idx] : 8'h00;
      pr = load_ready;
      @(negedge clk);
    end
    check("tri_acc3_cycle", acc3, LEN + 1);
    check("tri_count", idx, 3);

    // Reset mid-frame of F0 with a word also held
    load_data  = 8'hF0;
    load_valid = 1'b1;
    @(negedge clk);
    load_data = 8'h55;
    @(negedge clk);
    load_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mid_bit3", bit_out, 1'b1);
    check("mid_hold", load_ready, 1'b0);
    #2 reset = 1'b0;
    #1;
    check("async_valid", bit_valid, 1'b0);
    check("async_bit", bit_out, 1'b0);
    check("async_last", bit_last, 1'b0);
    check("async_busy", busy, 1'b0);
    check("async_ready", load_ready, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rel_valid", bit_valid, 1'b0);
    send_and_check("3c", 8'h3C);

    // LSB-first instance
    lsb_data  = 8'h01;
    lsb_valid = 1'b1;
    @(negedge clk);
    lsb_valid = 1'b0;
    wc = 8'h01;
    for (int i = 0; i < LEN; i++) begin
      check($sformatf("lsb_bit%0d", i), lsb_bit, frame_bit(wc, i, 1'b0));
      check($sformatf("lsb_last%0d", i), lsb_blast, (i == LEN - 1));
      @(negedge clk);
    end
    check("lsb_idle", lsb_bvalid, 1'b0);

`ifdef SEQUENCE_SERIALIZER_PARITY_EN
    send_and_check("par07", 8'h07);
    send_and_check("par03", 8'h03);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected finish before 200000");
    $fatal(1);
  end

endmodule

// File: doc/sequence_serializer.md
SEQUENCE_SERIALIZER -- requirements
Module: sequence_serializer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning data word width in bits (legal range 2..32).
REQ-002 SHALL have parameter MSB_FIRST, default 1, meaning 1 = bit WIDTH-1 sent first and 0 = bit 0 sent first.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on posedge clk.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port load_data  input  WIDTH  parallel word to serialize.
REQ-006 SHALL have port load_valid  input  1  load_data is valid this cycle.
REQ-007 SHALL have port load_ready  output  1  block can accept a word this cycle.
REQ-008 SHALL have port bit_out  output  1  current serial bit, feeding a downstream sequence detector.
REQ-009 SHALL have port bit_valid  output  1  bit_out carries a frame bit this cycle.
REQ-010 SHALL have port bit_last  output  1  bit_out is the final bit of the current frame.
REQ-011 SHALL have port busy  output  1  shifter or holding register is occupied.

Function
REQ-012 SHALL accept a word at a posedge where load_valid and load_ready are both 1; no other condition transfers data.
REQ-013 SHALL contain a WIDTH-bit shift register, a one-deep holding register, and a bit counter sized to count the frame length (WIDTH, or WIDTH+1 with parity).
REQ-014 SHALL implement states IDLE (shifter empty) and SHIFT (frame in progress); hold_full is a separate flag.
REQ-015 IDLE: an accepted word loads the shifter, counter = 0, next state SHIFT; first frame bit appears on bit_out with bit_valid=1 in the cycle after the accepting edge (latency 1).
REQ-016 SHIFT: each posedge advances one bit; bit_last=1 exactly when counter = frame length-1.
REQ-017 At the edge ending the last bit: if hold_full, the held word moves to the shifter and hold_full clears; else if a word is accepted that edge, it loads the shifter directly; else next state IDLE. Back-to-back frames SHALL have zero idle cycles between them.
REQ-018 A word accepted in SHIFT while not on the last bit SHALL go to the holding register and set hold_full.
REQ-019 load_ready SHALL equal NOT hold_full (combinational, no dependence on load_valid).
REQ-020 Simultaneous last-bit and acceptance with hold_full=1 SHALL not occur because load_ready=0; data SHALL never be dropped or duplicated.
REQ-021 In IDLE, bit_valid=0, bit_last=0 and bit_out=0.
REQ-022 busy SHALL be 1 whenever state=SHIFT or hold_full=1.
REQ-023 load_data SHALL be sampled only at the accepting edge; later changes SHALL not affect the frame.

Reset
REQ-024 reset=0 SHALL immediately force state IDLE, hold_full=0, counter=0, shift and hold registers=0.
REQ-025 During and after reset: load_ready=1, bit_out=0, bit_valid=0, bit_last=0, busy=0.
REQ-026 Reset asserted mid-frame SHALL abandon the frame and held word; the first accepted word after release starts a fresh frame.

Configuration
REQ-027 Macro SEQUENCE_SERIALIZER_PARITY_EN SHALL, when defined, append one even-parity bit (XOR of all WIDTH data bits) after the data bits; frame length WIDTH+1 and bit_last marks the parity bit.
REQ-028 Without SEQUENCE_SERIALIZER_PARITY_EN, frame length SHALL be WIDTH and no parity logic SHALL be present.

Verification
REQ-029 Single word 8'hA5, MSB_FIRST=1 -> bit_out 1,0,1,0,0,1,0,1 on 8 consecutive bit_valid cycles, bit_last only on 8th, then IDLE.
REQ-030 Words 8'h00 then 8'hFF presented back-to-back with load_valid held -> 16 consecutive bit_valid cycles, bit_last on cycles 8 and 16, load_ready low while second word is held.
REQ-031 Three words offered continuously -> third accepted only at the edge after hold_full clears; output stream order word1, word2, word3 with no gaps.
REQ-032 reset pulled low at bit 4 of 8'hF0 -> outputs zero asynchronously; after release, 8'h3C sent cleanly as 0,0,1,1,1,1,0,0.
REQ-033 MSB_FIRST=0, word 8'h01 -> bit_out 1,0,0,0,0,0,0,0.
REQ-034 PARITY_EN defined, word 8'h07 -> 8 data bits then parity bit 1 with bit_last; word 8'h03 -> parity bit 0.
